// File: rtl/cpu_mem_ctrl_pkg.sv
// Shared types and constants for the CPU memory controller slice.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_ACK,
    I_WAIT,
    I_RESP,
    D_WACK,
    D_RACK,
    D_WAIT,
    D_RESP
  } state_t;

  // Width of the response-delay down-counter (RESP_DELAY range 0..15).
  localparam int unsigned DLY_W = 4;

endpackage

// File: rtl/cpu_mem_ctrl_if.sv
// Instruction and data request/response channels between CPU and memory controller.
interface cpu_mem_ctrl_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ack;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ack;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ack;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ack;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ack,
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ack,
    input  Inst_Req_Ack, Instruction, Inst_Valid,
    input  Mem_Req_Ack, Read_data, Read_data_Valid
  );

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ack,
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ack,
    output Inst_Req_Ack, Instruction, Inst_Valid,
    output Mem_Req_Ack, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/cpu_mem_ctrl_sp_ram.sv
// Single-port word RAM: synchronous byte-enabled write, registered one-cycle read.
module sp_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// Arbitrates instruction fetch and data read/write requests onto one shared RAM,
// returning read results through valid/ack response channels.
module cpu_mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned RESP_DELAY = 0
) (
  input  logic           clk,
  input  logic           rst,
  cpu_mem_ctrl_if.slave  bus
);

  localparam int unsigned       DLY_M1   = (RESP_DELAY > 0) ? RESP_DELAY - 1 : 0;
  localparam logic [DLY_W-1:0]  DLY_LOAD = DLY_M1[DLY_W-1:0];

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [31:0]       resp_q;
  logic [DLY_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] live_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.PC[31:ADDR_W+2], bus.PC[1:0],
                              bus.Address[31:ADDR_W+2], bus.Address[1:0]};

  // The RAM read is launched at the edge that accepts the request, so the data
  // lands in resp_q at the edge leaving the *ACK state (one cycle after issue).
  assign live_addr = (bus.MemWrite || bus.MemRead) ? bus.Address[ADDR_W+1:2]
                                                   : bus.PC[ADDR_W+1:2];
  assign ram_addr  = (state == IDLE) ? live_addr : addr_q;
  assign ram_we    = (state == D_WACK);

  sp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (strb_q),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.MemWrite)            state_nx = D_WACK;
        else if (bus.MemRead)        state_nx = D_RACK;
        else if (bus.Inst_Req_Valid) state_nx = I_ACK;
      end
      I_ACK:   state_nx = (RESP_DELAY > 0) ? I_WAIT : I_RESP;
      I_WAIT:  if (cnt_q == '0) state_nx = I_RESP;
      I_RESP:  if (bus.Inst_Ack) state_nx = IDLE;
      D_WACK:  state_nx = IDLE;
      D_RACK:  state_nx = (RESP_DELAY > 0) ? D_WAIT : D_RESP;
      D_WAIT:  if (cnt_q == '0) state_nx = D_RESP;
      D_RESP:  if (bus.Read_data_Ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (state == IDLE) begin
        addr_q  <= live_addr;
        wdata_q <= bus.Write_data;
        strb_q  <= bus.Write_strb;
      end
      if (state == I_ACK || state == D_RACK) begin
        resp_q <= ram_rdata;
        cnt_q  <= DLY_LOAD;
      end
      if ((state == I_WAIT || state == D_WAIT) && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign bus.Inst_Req_Ack    = (state == I_ACK);
  assign bus.Mem_Req_Ack     = (state == D_WACK) || (state == D_RACK);
  assign bus.Inst_Valid      = (state == I_RESP);
  assign bus.Read_data_Valid = (state == D_RESP);
  assign bus.Instruction     = resp_q;
  assign bus.Read_data       = resp_q;

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Directed and randomized bench for cpu_mem_ctrl with RESP_DELAY 0 and 3 instances.
module tb_cpu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc[2], addr[2], wd[2], inst[2], rdat[2];
  logic [3:0]  ws[2];
  logic        irv[2], iack[2], mw[2], mr[2], rack[2];
  logic        irq_ack[2], mreq_ack[2], ivld[2], dvld[2];

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [2][4096];

  cpu_mem_ctrl_if bus0 ();
  cpu_mem_ctrl_if bus3 ();

`define TB_BIND(B, I) \
  assign B.PC = pc[I]; assign B.Inst_Req_Valid = irv[I]; assign B.Inst_Ack = iack[I]; \
  assign B.Address = addr[I]; assign B.MemWrite = mw[I]; assign B.Write_data = wd[I]; \
  assign B.Write_strb = ws[I]; assign B.MemRead = mr[I]; assign B.Read_data_Ack = rack[I]; \
  assign irq_ack[I] = B.Inst_Req_Ack; assign mreq_ack[I] = B.Mem_Req_Ack; \
  assign ivld[I] = B.Inst_Valid; assign dvld[I] = B.Read_data_Valid; \
  assign inst[I] = B.Instruction; assign rdat[I] = B.Read_data;

  `TB_BIND(bus0, 0)
  `TB_BIND(bus3, 1)

  cpu_mem_ctrl #(.ADDR_W(12), .RESP_DELAY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  cpu_mem_ctrl #(.ADDR_W(12), .RESP_DELAY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int d);
    irv[d] = 1'b0; iack[d] = 1'b0; mw[d] = 1'b0; mr[d] = 1'b0; rack[d] = 1'b0;
  endtask

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [31:0] w;
    w = mdl[d][a[13:2]];
    for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
    mdl[d][a[13:2]] = w;
  endtask

  // kind: 0 fetch, 1 data read, 2 data write. hold = cycles Valid is left high before Ack.
  task automatic txn(input int d, input int kind, input logic [31:0] a, input logic [31:0] data,
                     input logic [3:0] strb, input int hold, input bit early, input bit intrude);
    int lat, ack_k, vld_k, vcnt;
    bit stray, done, v, ra_ok, ra_other, ackv;
    logic [31:0] expd, dat;
    lat = 2 + ((d == 0) ? 0 : 3);
    ack_k = 0; vld_k = 0; vcnt = 0; stray = 0; done = 0;
    expd = mdl[d][a[13:2]];
    @(negedge clk);
    case (kind)
      0:       begin pc[d] = a; irv[d] = 1'b1; end
      1:       begin addr[d] = a; mr[d] = 1'b1; end
      default: begin addr[d] = a; wd[d] = data; ws[d] = strb; mw[d] = 1'b1; end
    endcase
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      ra_ok    = (kind == 0) ? irq_ack[d] : mreq_ack[d];
      ra_other = (kind == 0) ? mreq_ack[d] : irq_ack[d];
      if (ra_other) stray = 1;
      if (ra_ok) begin
        if (ack_k == 0) begin
          ack_k = k; irv[d] = 1'b0; mr[d] = 1'b0; mw[d] = 1'b0;
        end else stray = 1;
      end
      if (intrude && k == 2) begin mw[d] = 1'b1; ws[d] = 4'hF; wd[d] = ~expd; end
      if (intrude && k == 3) mw[d] = 1'b0;
      if (kind == 2) begin
        if (ack_k != 0 && k >= ack_k + 3) done = 1;
      end else begin
        v   = (kind == 0) ? ivld[d] : dvld[d];
        dat = (kind == 0) ? inst[d] : rdat[d];
        ackv = 1'b0;
        if (v) begin
          if (vld_k == 0) vld_k = k;
          vcnt++;
          check((kind == 0) ? "fetch_data" : "read_data", dat, expd);
          ackv = (vcnt == hold);
        end else if (vld_k != 0) begin
          done = 1;
        end else begin
          ackv = early && (k + 1 < lat);
        end
        if (kind == 0) iack[d] = ackv; else rack[d] = ackv;
      end
    end
    idle_inputs(d);
    check("txn_done", 32'(done), 32'd1);
    check("req_ack_cycle", 32'(ack_k), 32'd1);
    check("stray_req_ack", 32'(stray), 32'd0);
    if (kind == 2) model_write(d, a, data, strb);
    else begin
      check("valid_cycle", 32'(vld_k), 32'(lat));
      check("valid_len", 32'(vcnt), 32'(hold));
    end
  endtask

  initial begin
    int mk, ik, fk;
    bit saw;
    logic [31:0] fdat;
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d); pc[d] = '0; addr[d] = '0; wd[d] = '0; ws[d] = '0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ctl", {28'd0, irq_ack[d], mreq_ack[d], ivld[d], dvld[d]}, 32'd0);
      check("reset_inst", inst[d], 32'd0);
      check("reset_rdata", rdat[d], 32'd0);
    end
    rst = 1'b1;

    // Preload words 0..15 of both RAMs through the write channel.
    for (int w = 0; w < 16; w++) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] v;
        v = (w == 0) ? 32'h3C01_0001 : (w == 4) ? 32'hAABB_CCDD : $urandom();
        txn(d, 2, 32'(w) << 2, v, 4'hF, 1, 0, 0);
      end
    end

    txn(0, 0, 32'h0000_0000, '0, '0, 3, 0, 0);              // fetch 0x3C010001, held 3 cycles
    txn(0, 2, 32'h0000_0010, 32'h0011_0000, 4'b0100, 1, 0, 0);
    txn(0, 1, 32'h0000_0010, '0, '0, 1, 0, 0);              // expect 0xAA11CCDD
    check("byte_merge_model", mdl[0][4], 32'hAA11_CCDD);
    txn(0, 2, 32'h0000_0014, 32'hDEAD_BEEF, 4'b0000, 1, 0, 0);
    txn(0, 1, 32'h0000_0014, '0, '0, 2, 0, 0);              // zero strobe leaves word 5
    txn(1, 1, 32'h0000_4004, '0, '0, 1, 1, 0);              // wraps to word 1, latency 5
    txn(1, 1, 32'h0000_0008, '0, '0, 2, 0, 1);              // write pulse during wait ignored
    txn(1, 1, 32'h0000_0008, '0, '0, 1, 0, 0);

    // Write and fetch raised together: write wins, fetch follows after IDLE.
    @(negedge clk);
    mw[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    irv[0] = 1'b1; pc[0] = 32'h8;
    mk = 0; ik = 0; fk = 0; fdat = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mreq_ack[0] && mk == 0) begin mk = k; mw[0] = 1'b0; end
      if (irq_ack[0] && ik == 0) begin ik = k; irv[0] = 1'b0; end
      iack[0] = 1'b0;
      if (ivld[0]) begin
        if (fk == 0) begin fk = k; fdat = inst[0]; end
        iack[0] = 1'b1;
      end
    end
    idle_inputs(0);
    check("prio_mem_ack", 32'(mk), 32'd1);
    check("prio_inst_ack", 32'(ik), 32'd3);
    check("prio_fetch_valid", 32'(fk), 32'd4);
    check("prio_fetch_data", fdat, mdl[0][2]);
    model_write(0, 32'h20, 32'h1234_5678, 4'hF);
    txn(0, 1, 32'h0000_0020, '0, '0, 1, 0, 0);

    // Fetch request withdrawn before any rising edge samples it.
    @(negedge clk);
    pc[0] = 32'h0; irv[0] = 1'b1;
    #2 irv[0] = 1'b0;
    saw = 0;
    repeat (4) begin
      @(negedge clk);
      saw |= irq_ack[0] | mreq_ack[0] | ivld[0] | dvld[0];
    end
    check("withdrawn_req", 32'(saw), 32'd0);

    // Reset while the delayed read is waiting.
    @(negedge clk);
    addr[1] = 32'h4004; mr[1] = 1'b1;
    @(negedge clk); mr[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ctl", {28'd0, irq_ack[1], mreq_ack[1], ivld[1], dvld[1]}, 32'd0);
    check("midrst_rdata", rdat[1], 32'd0);
    check("midrst_inst", inst[1], 32'd0);
    @(negedge clk); rst = 1'b1;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      saw |= dvld[1] | ivld[1];
    end
    check("midrst_no_resp", 32'(saw), 32'd0);
    txn(1, 0, 32'h0000_000C, '0, '0, 1, 0, 0);

    // Randomized traffic across both instances; upper address bits exercise wrap.
    for (int n = 0; n < 40; n++) begin
      int d, kind, w;
      logic [31:0] a;
      d = $urandom_range(0, 1);
      kind = $urandom_range(0, 2);
      w = $urandom_range(0, 15);
      a = ($urandom() & 32'hFFFF_C003) | (32'(w) << 2);
      txn(d, kind, a, $urandom(), 4'($urandom_range(0, 15)),
          $urandom_range(1, 3), 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
